// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with a req/ack backing port.
// Optional hit/miss/write counters are enabled with the DCACHE_STATS_EN macro.
module dcache_wt #(
  parameter int N     = 64,
  parameter int LINES = 64,
  parameter int STATW = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memread,
  input  logic [1:0]       memwrite,
  input  logic             dword,
  input  logic [N-1:0]     adr,
  input  logic [N-1:0]     wdata,
  output logic [N-1:0]     rdata,
  output logic             ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic [N-1:0]     mem_adr,
  output logic [N-1:0]     mem_wdata,
  output logic [N/8-1:0]   mem_be,
  input  logic [N-1:0]     mem_rdata,
  input  logic             mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [STATW-1:0] hitcnt,
  output logic [STATW-1:0] misscnt,
  output logic [STATW-1:0] wrcnt
`endif
);

  localparam int OFF = $clog2(N / 8);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = N - OFF - IDX;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [LINES-1:0] valid_reg;
  logic [TAG-1:0]   tag_mem  [LINES];
  logic [N-1:0]     data_mem [LINES];
  logic [N-1:0]     rdata_reg;
  logic             sel_hi_reg, dword_reg, whit_reg;

  logic [IDX-1:0]   idx, cur_idx;
  logic [TAG-1:0]   cur_tag;
  logic [N-1:0]     line, line_adr, hit_rdata, fill_rdata, store_data, merged;
  logic [N/8-1:0]   store_be;
  logic             hit, is_store, is_load, load_hit;

  assign idx      = adr[OFF +: IDX];
  assign line     = data_mem[idx];
  assign hit      = valid_reg[idx] && (tag_mem[idx] == adr[N-1 -: TAG]);
  assign line_adr = {adr[N-1:OFF], {OFF{1'b0}}};
  assign cur_idx  = mem_adr[OFF +: IDX];
  assign cur_tag  = mem_adr[N-1 -: TAG];
  assign is_store = |memwrite;
  assign is_load  = memread && !is_store;
  assign load_hit = (state_reg == IDLE) && is_load && hit;

  generate
    if (N == 64) begin : g_w64
      logic bits_unused;
      assign bits_unused = ^adr[1:0];
      assign hit_rdata   = dword ? line : {32'b0, adr[2] ? line[63:32] : line[31:0]};
      assign fill_rdata  = dword_reg ? mem_rdata
                         : {32'b0, sel_hi_reg ? mem_rdata[63:32] : mem_rdata[31:0]};
      assign store_be    = memwrite[1] ? 8'hFF : (adr[2] ? 8'hF0 : 8'h0F);
      assign store_data  = memwrite[1] ? wdata : {wdata[31:0], wdata[31:0]};
    end else begin : g_w32
      logic bits_unused;
      assign bits_unused = ^{adr[OFF-1:0], dword, memwrite[1], sel_hi_reg, dword_reg};
      assign hit_rdata   = line;
      assign fill_rdata  = mem_rdata;
      assign store_be    = '1;
      assign store_data  = wdata;
    end
  endgenerate

  // Bytes outside the store lanes come from the resident line so the
  // backing write carries a full, coherent word.
  generate
    for (genvar gi = 0; gi < N / 8; gi++) begin : g_merge
      assign merged[gi*8 +: 8] = store_be[gi] ? store_data[gi*8 +: 8]
                                              : (hit ? line[gi*8 +: 8] : 8'h00);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (is_store)                state_next = WRITE;
        else if (memread && !hit)    state_next = FILL;
      end
      FILL:  if (mem_ack) state_next = DONE;
      WRITE: if (mem_ack) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_req = (state_reg == FILL) || (state_reg == WRITE);
  assign mem_we  = (state_reg == WRITE);
  assign ready   = load_hit || (state_reg == DONE);
  assign rdata   = load_hit ? hit_rdata : rdata_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      valid_reg  <= '0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      rdata_reg  <= '0;
      sel_hi_reg <= 1'b0;
      dword_reg  <= 1'b0;
      whit_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && is_store) begin
        mem_adr   <= line_adr;
        mem_wdata <= merged;
        mem_be    <= store_be;
        whit_reg  <= hit;
      end else if (state_reg == IDLE && memread && !hit) begin
        mem_adr    <= line_adr;
        mem_be     <= '0;
        sel_hi_reg <= adr[OFF-1];
        dword_reg  <= dword;
      end
      if (state_reg == FILL && mem_ack) begin
        valid_reg[cur_idx] <= 1'b1;
        rdata_reg          <= fill_rdata;
      end
    end
  end

  // Array contents need no reset; only valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!reset && mem_ack) begin
      if (state_reg == FILL) begin
        data_mem[cur_idx] <= mem_rdata;
        tag_mem[cur_idx]  <= cur_tag;
      end else if (state_reg == WRITE && whit_reg) begin
        data_mem[cur_idx] <= mem_wdata;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hitcnt  <= '0;
      misscnt <= '0;
      wrcnt   <= '0;
    end else begin
      if (load_hit)                                 hitcnt  <= hitcnt + STATW'(1);
      if (state_reg == IDLE && state_next == FILL)  misscnt <= misscnt + STATW'(1);
      if (state_reg == IDLE && state_next == WRITE) wrcnt   <= wrcnt + STATW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt (N=64, LINES=64) with a hand-driven backing memory.
module tb_dcache_wt;
  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic [1:0]  memwrite;
  logic        dword;
  logic [63:0] adr, wdata, rdata;
  logic        ready, mem_req, mem_we;
  logic [63:0] mem_adr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hitcnt, misscnt, wrcnt;
`endif

  int total = 0;
  int bad   = 0;
  logic        cap_we;
  logic [63:0] cap_adr, cap_wdata;
  logic [7:0]  cap_be;

  dcache_wt #(.N(64), .LINES(64), .STATW(32)) dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite), .dword(dword),
    .adr(adr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hitcnt(hitcnt), .misscnt(misscnt), .wrcnt(wrcnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // One core access; the backing side acks on the dly-th request cycle.
  task automatic access(input string nm, input logic rd, input logic [1:0] wr, input logic dw,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] fill,
                        input int dly, input int exp_reqs, input logic [63:0] exp_rdata,
                        input logic chk_rd);
    int reqs;
    bit done;
    @(negedge clk);
    memread = rd; memwrite = wr; dword = dw; adr = a; wdata = wd; mem_rdata = fill;
    #1;
    if (exp_reqs == 0) begin
      chk({nm, "_ready_now"}, {63'b0, ready}, 64'd1);
      chk({nm, "_noreq"}, {63'b0, mem_req}, 64'd0);
    end else begin
      chk({nm, "_ready_low"}, {63'b0, ready}, 64'd0);
    end
    reqs = 0;
    done = (exp_reqs == 0) && ready;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      if (ready) done = 1'b1;
      else if (mem_req) begin
        reqs++;
        if (reqs == 1) begin
          cap_we = mem_we; cap_adr = mem_adr; cap_be = mem_be; cap_wdata = mem_wdata;
        end
        if (reqs == dly) mem_ack = 1'b1;
      end
    end
    chk({nm, "_done"}, {63'b0, done}, 64'd1);
    chk({nm, "_reqs"}, 64'(reqs), 64'(exp_reqs));
    if (chk_rd) chk({nm, "_rdata"}, rdata, exp_rdata);
    $display("access %s adr=%h reqs=%0d rdata=%h", nm, a, reqs, rdata);
    @(negedge clk);
    memread = 1'b0; memwrite = 2'b00; mem_ack = 1'b0;
    #1;
    chk({nm, "_idle"}, {63'b0, ready}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; memread = 1'b0; memwrite = 2'b00; dword = 1'b1;
    adr = '0; wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    cap_we = 1'b0; cap_adr = '0; cap_wdata = '0; cap_be = '0;
    @(negedge clk); #1;
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_req", {63'b0, mem_req}, 64'd0);
    chk("rst_we", {63'b0, mem_we}, 64'd0);
    chk("rst_adr", mem_adr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_be", {56'b0, mem_be}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    @(negedge clk); reset = 1'b0;

    access("cold", 1'b1, 2'b00, 1'b1, 64'h40, 64'h0, 64'h1122334455667788, 3, 3,
           64'h1122334455667788, 1'b1);
    chk("cold_we", {63'b0, cap_we}, 64'd0);
    chk("cold_adr", cap_adr, 64'h40);
    access("hit1", 1'b1, 2'b00, 1'b1, 64'h40, 64'h0, 64'h0, 0, 0, 64'h1122334455667788, 1'b1);

    access("dst", 1'b0, 2'b10, 1'b1, 64'h40, 64'hDEADBEEF00000000, 64'h0, 1, 1, 64'h0, 1'b0);
    chk("dst_we", {63'b0, cap_we}, 64'd1);
    chk("dst_be", {56'b0, cap_be}, 64'hFF);
    chk("dst_wdata", cap_wdata, 64'hDEADBEEF00000000);
    access("hit2", 1'b1, 2'b00, 1'b1, 64'h40, 64'h0, 64'h0, 0, 0, 64'hDEADBEEF00000000, 1'b1);

    access("wst", 1'b0, 2'b01, 1'b0, 64'h44, 64'h00000000CAFEBABE, 64'h0, 2, 2, 64'h0, 1'b0);
    chk("wst_be", {56'b0, cap_be}, 64'hF0);
    chk("wst_wdata", cap_wdata, 64'hCAFEBABE00000000);
    chk("wst_adr", cap_adr, 64'h40);
    access("wld", 1'b1, 2'b00, 1'b0, 64'h44, 64'h0, 64'h0, 0, 0, 64'h00000000CAFEBABE, 1'b1);

    access("alias", 1'b1, 2'b00, 1'b1, 64'h240, 64'h0, 64'hA5A5A5A5A5A5A5A5, 1, 1,
           64'hA5A5A5A5A5A5A5A5, 1'b1);
    chk("alias_adr", cap_adr, 64'h240);
    access("alias_back", 1'b1, 2'b00, 1'b1, 64'h40, 64'h0, 64'h0123456789ABCDEF, 2, 2,
           64'h0123456789ABCDEF, 1'b1);

    @(negedge clk); mem_ack = 1'b1; #1;
    chk("stray_ack_req", {63'b0, mem_req}, 64'd0);
    @(negedge clk); mem_ack = 1'b0; #1;
    chk("stray_ack_ready", {63'b0, ready}, 64'd0);
    access("lo_word", 1'b1, 2'b00, 1'b0, 64'h40, 64'h0, 64'h0, 0, 0, 64'h0000000089ABCDEF, 1'b1);

    access("wmiss", 1'b0, 2'b01, 1'b0, 64'h1000, 64'h11223344, 64'h0, 1, 1, 64'h0, 1'b0);
    chk("wmiss_be", {56'b0, cap_be}, 64'h0F);
    access("wmiss_ld", 1'b1, 2'b00, 1'b1, 64'h1000, 64'h0, 64'h7777, 1, 1, 64'h7777, 1'b1);

    @(negedge clk); memread = 1'b1; dword = 1'b1; adr = 64'h80;
    @(negedge clk); #1;
    chk("abort_req_on", {63'b0, mem_req}, 64'd1);
    #2 reset = 1'b1; #1;
    chk("abort_req_off", {63'b0, mem_req}, 64'd0);
    chk("abort_ready", {63'b0, ready}, 64'd0);
    $display("access abort adr=0080 mem_req=%b", mem_req);
    @(negedge clk); reset = 1'b0; memread = 1'b0;
    access("post_rst", 1'b1, 2'b00, 1'b1, 64'h80, 64'h0, 64'hBEEF, 1, 1, 64'hBEEF, 1'b1);
    access("post_rst40", 1'b1, 2'b00, 1'b1, 64'h40, 64'h0, 64'h42, 1, 1, 64'h42, 1'b1);

`ifdef DCACHE_STATS_EN
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    access("st_miss", 1'b1, 2'b00, 1'b1, 64'hC0, 64'h0, 64'h99, 1, 1, 64'h99, 1'b1);
    access("st_hit1", 1'b1, 2'b00, 1'b1, 64'hC0, 64'h0, 64'h0, 0, 0, 64'h99, 1'b1);
    access("st_hit2", 1'b1, 2'b00, 1'b1, 64'hC0, 64'h0, 64'h0, 0, 0, 64'h99, 1'b1);
    access("st_wr", 1'b0, 2'b10, 1'b1, 64'hC0, 64'h5, 64'h0, 1, 1, 64'h0, 1'b0);
    chk("misscnt", 64'(misscnt), 64'd1);
    chk("hitcnt", 64'(hitcnt), 64'd2);
    chk("wrcnt", 64'(wrcnt), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
